// File: rtl/blueberry_pkg.sv
// Shared types and constants for the program sequencer: FSM state encoding,
// default word width and the timestep width/encodings used by the controller.
package blueberry_pkg;

  localparam int BB_WORD_W = 10;
  localparam int TS_W      = 2;

  typedef logic [TS_W-1:0] ts_t;

  localparam ts_t TS0 = 2'd0;
  localparam ts_t TS1 = 2'd1;
  localparam ts_t TS2 = 2'd2;
  localparam ts_t TS3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_STEP,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/program_sequencer_if.sv
// Control, program-memory and bus signals of the program sequencer.
// The slave modport is the sequencer's view; master is the environment's.
interface program_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = blueberry_pkg::BB_WORD_W
);
  logic              run_i;
  logic              step_i;
  logic              halt_req_i;
  logic              clr_i;
  logic              ext_i;
  logic [ADDR_W-1:0] last_addr_i;
  logic [ADDR_W-1:0] prog_addr_o;
  logic [WORD_W-1:0] prog_data_i;
  logic [WORD_W-1:0] data_o;
  logic [1:0]        timestep_o;
  logic              hold_o;
  logic              done_o;
  logic              err_o;
  logic              bp_en_i;
  logic [ADDR_W-1:0] bp_addr_i;
  logic              bp_hit_o;

  modport slave (
    input  run_i, step_i, halt_req_i, clr_i, ext_i, last_addr_i, prog_data_i,
           bp_en_i, bp_addr_i,
    output prog_addr_o, data_o, timestep_o, hold_o, done_o, err_o, bp_hit_o
  );

  modport master (
    output run_i, step_i, halt_req_i, clr_i, ext_i, last_addr_i, prog_data_i,
           bp_en_i, bp_addr_i,
    input  prog_addr_o, data_o, timestep_o, hold_o, done_o, err_o, bp_hit_o
  );
endinterface

// File: rtl/timestep_counter.sv
// Instruction timestep counter: clears on instruction complete, otherwise
// counts; a 3->0 wrap without completion sets a sticky error flag.
module timestep_counter
  import blueberry_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic clr_i,
  input  logic err_clr_i,
  output ts_t  ts_o,
  output logic err_o
);

  ts_t  ts_q, ts_d;
  logic err_q, err_d;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    ts_d  = TS0;
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (active_i) begin
      if (clr_i) begin
        ts_d = TS0;
      end else begin
        ts_d = ts_q + TS1;
        if (ts_q == TS3) err_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q  <= TS0;
      err_q <= 1'b0;
    end else begin
      ts_q  <= ts_d;
      err_q <= err_d;
    end
  end

  assign ts_o  = ts_q;
  assign err_o = err_q;

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: walks the program counter through memory, paces the
// controller's timesteps and supports run/halt/single-step control.
// Optional breakpoint logic is enabled by defining BLUEBERRY_BREAKPOINT_EN.
module program_sequencer
  import blueberry_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = BB_WORD_W
) (
  input logic              clk,
  input logic              rst_n,
  program_sequencer_if.slave bus
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              active;
  logic              boundary;
  logic              past_end;
  logic              restart;
  logic              bp_match;
  ts_t               ts;
  logic              err;

  assign active   = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign boundary = active && bus.clr_i;
  assign pc_inc   = pc_q + ADDR_W'(1);
  // The PC wraps silently, so a wrapped next PC never reads as past the end.
  assign past_end = pc_inc > bus.last_addr_i;
  assign restart  = bus.run_i &&
                    (((state_q == ST_IDLE) && !bus.halt_req_i) || (state_q == ST_DONE));

  timestep_counter u_ts (
    .clk       (clk),
    .rst_n     (rst_n),
    .active_i  (active),
    .clr_i     (bus.clr_i),
    .err_clr_i (restart),
    .ts_o      (ts),
    .err_o     (err)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (restart) state_d = ST_RUN;
      ST_RUN: begin
        if (boundary) begin
          if (past_end)                         state_d = ST_DONE;
          else if (bus.halt_req_i || bp_match)  state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (bus.run_i)       state_d = ST_RUN;
        else if (bus.step_i) state_d = ST_STEP;
      end
      ST_STEP:   if (boundary) state_d = past_end ? ST_DONE : ST_PAUSED;
      ST_DONE:   if (restart) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (restart)                              pc_d = '0;
    else if (active && (bus.clr_i || bus.ext_i)) pc_d = pc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef BLUEBERRY_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;

  assign bp_match = bus.bp_en_i && (pc_inc == bus.bp_addr_i);
  // A completing program wins over the breakpoint, so no pulse in that case.
  assign bp_hit_d = (state_q == ST_RUN) && boundary && !past_end && bp_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bp_hit_q <= 1'b0;
    else        bp_hit_q <= bp_hit_d;
  end

  assign bus.bp_hit_o = bp_hit_q;
`else
  logic bp_unused;

  assign bp_unused    = ^{bus.bp_en_i, bus.bp_addr_i};
  assign bp_match     = 1'b0;
  assign bus.bp_hit_o = 1'b0;
`endif

  assign bus.prog_addr_o = pc_q;
  assign bus.data_o      = active ? bus.prog_data_i : '0;
  assign bus.timestep_o  = ts;
  assign bus.hold_o      = !active;
  assign bus.done_o      = (state_q == ST_DONE);
  assign bus.err_o       = err;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed scoreboard bench for program_sequencer: the driver queues the
// expected output snapshot each cycle and a monitor compares it on the falling edge.
module tb_program_sequencer;

  localparam logic [9:0] COPY  = 10'h040;
  localparam logic [9:0] ADD   = 10'h0C1;
  localparam logic [9:0] LOAD  = 10'h100;
  localparam logic [9:0] OPND  = 10'h155;
  localparam logic [9:0] UNDEF = 10'h3FF;

  typedef struct {
    string       name;
    logic [23:0] v;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [9:0] mem [256];
  exp_t exp_q [$];
  int   checks;
  int   failures;
  event mon_ev;

  program_sequencer_if #(.ADDR_W(8), .WORD_W(10)) bus ();

  program_sequencer #(.ADDR_W(8), .WORD_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.prog_data_i = mem[bus.prog_addr_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Monitor: drains whatever expectations the driver queued for this sample point.
  always begin
    logic [23:0] act;
    exp_t        e;
    @(negedge clk or mon_ev);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {bus.timestep_o, bus.prog_addr_o, bus.data_o,
             bus.hold_o, bus.done_o, bus.err_o, bus.bp_hit_o};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got ts/pc/data/hold/done/err/bp=%h expected %h", e.name, act, e.v);
      end
    end
  end

  function automatic logic [23:0] pack(logic [1:0] ts, logic [7:0] pc, logic [9:0] data,
                                       bit hold, bit done, bit err, bit bp);
    return {ts, pc, data, hold, done, err, bp};
  endfunction

  task automatic cyc(string nm, bit run, bit step, bit halt, bit clr, bit ext,
                     logic [1:0] ts, logic [7:0] pc, logic [9:0] data,
                     bit hold, bit done, bit err, bit bp);
    exp_t e;
    @(posedge clk);
    #1;
    bus.run_i      = run;
    bus.step_i     = step;
    bus.halt_req_i = halt;
    bus.clr_i      = clr;
    bus.ext_i      = ext;
    e.name = nm;
    e.v    = pack(ts, pc, data, hold, done, err, bp);
    exp_q.push_back(e);
  endtask

  task automatic push_now(string nm);
    exp_t e;
    e.name = nm;
    e.v    = pack(2'd0, 8'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(e);
    -> mon_ev;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = UNDEF;
    mem[0] = COPY; mem[1] = ADD; mem[2] = LOAD; mem[3] = OPND;
    mem[4] = COPY; mem[5] = ADD;

    rst_n           = 1'b0;
    bus.run_i       = 1'b0;
    bus.step_i      = 1'b0;
    bus.halt_req_i  = 1'b0;
    bus.clr_i       = 1'b0;
    bus.ext_i       = 1'b0;
    bus.last_addr_i = 8'd3;
    bus.bp_en_i     = 1'b0;
    bus.bp_addr_i   = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full program run, plus simultaneous-event corner cases in IDLE/RUN.
    cyc("idle_after_rst", 0,0,0,0,0, 2'd0, 8'd0, 10'd0, 1,0,0,0);
    cyc("idle_run_halt",  1,0,1,0,0, 2'd0, 8'd0, 10'd0, 1,0,0,0);
    cyc("idle_step",      0,1,0,0,0, 2'd0, 8'd0, 10'd0, 1,0,0,0);
    cyc("idle_run",       1,0,0,0,0, 2'd0, 8'd0, 10'd0, 1,0,0,0);
    cyc("copy_t0",        0,0,0,0,0, 2'd0, 8'd0, COPY,  0,0,0,0);
    cyc("copy_t1",        0,0,0,1,0, 2'd1, 8'd0, COPY,  0,0,0,0);
    cyc("add_t0",         0,0,0,0,0, 2'd0, 8'd1, ADD,   0,0,0,0);
    cyc("add_t1_step",    0,1,0,0,0, 2'd1, 8'd1, ADD,   0,0,0,0);
    cyc("add_t2",         0,0,0,0,0, 2'd2, 8'd1, ADD,   0,0,0,0);
    cyc("add_t3",         0,0,0,1,0, 2'd3, 8'd1, ADD,   0,0,0,0);
    cyc("load_t0",        0,0,0,0,1, 2'd0, 8'd2, LOAD,  0,0,0,0);
    cyc("load_t1",        0,0,0,1,0, 2'd1, 8'd3, OPND,  0,0,0,0);
    cyc("done",           0,0,0,0,0, 2'd0, 8'd4, 10'd0, 1,1,0,0);
    cyc("done_hold",      0,0,0,0,0, 2'd0, 8'd4, 10'd0, 1,1,0,0);

    // Halt during ADD, then two single steps, then resume with run+step.
    bus.last_addr_i = 8'd5;
    cyc("done_run",       1,0,0,0,0, 2'd0, 8'd4, 10'd0, 1,1,0,0);
    cyc("h_copy_t0",      0,0,0,0,0, 2'd0, 8'd0, COPY,  0,0,0,0);
    cyc("h_copy_t1",      0,0,0,1,0, 2'd1, 8'd0, COPY,  0,0,0,0);
    cyc("h_add_t0",       0,0,0,0,0, 2'd0, 8'd1, ADD,   0,0,0,0);
    cyc("h_add_t1",       0,0,0,0,0, 2'd1, 8'd1, ADD,   0,0,0,0);
    cyc("h_add_t2",       0,0,1,0,0, 2'd2, 8'd1, ADD,   0,0,0,0);
    cyc("h_add_t3",       0,0,1,1,0, 2'd3, 8'd1, ADD,   0,0,0,0);
    cyc("paused",         0,0,0,0,0, 2'd0, 8'd2, 10'd0, 1,0,0,0);
    cyc("paused_step",    0,1,0,0,0, 2'd0, 8'd2, 10'd0, 1,0,0,0);
    cyc("step1_t0",       0,0,0,0,1, 2'd0, 8'd2, LOAD,  0,0,0,0);
    cyc("step1_t1",       0,0,0,1,0, 2'd1, 8'd3, OPND,  0,0,0,0);
    cyc("paused1_step",   0,1,0,0,0, 2'd0, 8'd4, 10'd0, 1,0,0,0);
    cyc("step2_t0",       0,0,0,0,0, 2'd0, 8'd4, COPY,  0,0,0,0);
    cyc("step2_t1",       0,0,0,1,0, 2'd1, 8'd4, COPY,  0,0,0,0);
    cyc("paused2_runstep",1,1,0,0,0, 2'd0, 8'd5, 10'd0, 1,0,0,0);
    cyc("r_add_t0",       0,0,0,0,0, 2'd0, 8'd5, ADD,   0,0,0,0);
    cyc("r_add_t1",       0,0,0,0,0, 2'd1, 8'd5, ADD,   0,0,0,0);
    cyc("r_add_t2",       0,0,0,0,0, 2'd2, 8'd5, ADD,   0,0,0,0);
    cyc("r_add_t3",       0,0,0,1,0, 2'd3, 8'd5, ADD,   0,0,0,0);
    cyc("done2",          0,0,0,0,0, 2'd0, 8'd6, 10'd0, 1,1,0,0);

    // Undefined opcode never completes: timestep wraps and err sticks.
    mem[0] = UNDEF;
    bus.last_addr_i = 8'd15;
    cyc("done2_run",      1,0,0,0,0, 2'd0, 8'd6, 10'd0, 1,1,0,0);
    cyc("u_t0",           0,0,0,0,0, 2'd0, 8'd0, UNDEF, 0,0,0,0);
    cyc("u_t1",           0,0,0,0,0, 2'd1, 8'd0, UNDEF, 0,0,0,0);
    cyc("u_t2",           0,0,0,0,0, 2'd2, 8'd0, UNDEF, 0,0,0,0);
    cyc("u_t3",           0,0,0,0,0, 2'd3, 8'd0, UNDEF, 0,0,0,0);
    cyc("u_wrap",         0,0,0,0,0, 2'd0, 8'd0, UNDEF, 0,0,1,0);
    cyc("u_t1_clr",       0,0,0,1,0, 2'd1, 8'd0, UNDEF, 0,0,1,0);
    cyc("e_add_t0",       0,0,0,0,0, 2'd0, 8'd1, ADD,   0,0,1,0);
    cyc("e_add_t1",       0,0,0,0,0, 2'd1, 8'd1, ADD,   0,0,1,0);
    cyc("e_add_t2",       0,0,0,0,0, 2'd2, 8'd1, ADD,   0,0,1,0);

    // Asynchronous reset in the middle of ADD timestep 2.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 push_now("rst_mid_ts2");
    @(posedge clk);
    #1 push_now("rst_held");
    rst_n = 1'b1;
    mem[0] = COPY;
    bus.last_addr_i = 8'd3;
    bus.bp_en_i     = 1'b1;
    bus.bp_addr_i   = 8'd2;
    cyc("rel_idle",       0,0,0,0,0, 2'd0, 8'd0, 10'd0, 1,0,0,0);
    cyc("rel_idle2",      0,0,0,0,0, 2'd0, 8'd0, 10'd0, 1,0,0,0);

    // Breakpoint at address 2.
    cyc("bp_run",         1,0,0,0,0, 2'd0, 8'd0, 10'd0, 1,0,0,0);
    cyc("b_copy_t0",      0,0,0,0,0, 2'd0, 8'd0, COPY,  0,0,0,0);
    cyc("b_copy_t1",      0,0,0,1,0, 2'd1, 8'd0, COPY,  0,0,0,0);
    cyc("b_add_t0",       0,0,0,0,0, 2'd0, 8'd1, ADD,   0,0,0,0);
    cyc("b_add_t1",       0,0,0,0,0, 2'd1, 8'd1, ADD,   0,0,0,0);
    cyc("b_add_t2",       0,0,0,0,0, 2'd2, 8'd1, ADD,   0,0,0,0);
    cyc("b_add_t3",       0,0,0,1,0, 2'd3, 8'd1, ADD,   0,0,0,0);
`ifdef BLUEBERRY_BREAKPOINT_EN
    cyc("bp_paused_hit",  0,0,0,0,0, 2'd0, 8'd2, 10'd0, 1,0,0,1);
    cyc("bp_pulse_end",   1,0,0,0,0, 2'd0, 8'd2, 10'd0, 1,0,0,0);
`endif
    cyc("b_load_t0",      0,0,0,0,1, 2'd0, 8'd2, LOAD,  0,0,0,0);
    cyc("b_load_t1",      0,0,0,1,0, 2'd1, 8'd3, OPND,  0,0,0,0);
    cyc("b_done",         0,0,0,0,0, 2'd0, 8'd4, 10'd0, 1,1,0,0);

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program-memory address width.
REQ-002 SHALL have parameter WORD_W, default 10, instruction/data word width.
REQ-003 SHALL have ports: clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: run_i  input  1 (start from PC 0); step_i  input  1 (single-step request); halt_req_i  input  1 (pause at next instruction boundary).
REQ-006 SHALL have ports: clr_i  input  1  instruction-complete from controller; ext_i  input  1  controller drives bus from external data.
REQ-007 SHALL have ports: last_addr_i  input  ADDR_W  address of final program word.
REQ-008 SHALL have ports: prog_addr_o  output  ADDR_W  program-memory address (= PC); prog_data_i  input  WORD_W  asynchronous-read memory word.
REQ-009 SHALL have ports: data_o  output  WORD_W  external data to shared bus; timestep_o  output  2  timestep to controller.
REQ-010 SHALL have ports: hold_o  output  1 (top level gates IRin/ENW); done_o  output  1; err_o  output  1 (sticky).
REQ-011 SHALL have ports: bp_en_i  input  1; bp_addr_i  input  ADDR_W; bp_hit_o  output  1.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, PAUSED, STEP, DONE.
REQ-013 SHALL make these transitions:
- IDLE/DONE + run_i -> RUN, PC=0, ts=0.
- RUN + boundary + halt_req_i -> PAUSED.
- PAUSED + step_i -> STEP.
- STEP + boundary -> PAUSED.
- PAUSED + run_i -> RUN, PC kept.
REQ-014 SHALL define boundary as a cycle where active (RUN or STEP) and clr_i=1.
REQ-015 SHALL, while active: ts<=0 if clr_i, else ts<=ts+1.
REQ-016 SHALL, while active, wrap ts 3->0 when clr_i=0 at ts=3, and set err_o.
REQ-017 SHALL, while active, increment PC on each cycle with ext_i=1, so LOAD consumes two words.
REQ-018 SHALL drive data_o=prog_data_i when active, else 0.
REQ-019 SHALL hold hold_o=1 and ts=0 outside RUN/STEP; PC frozen.
REQ-020 SHALL enter DONE at a boundary whose next PC exceeds last_addr_i.
REQ-021 SHALL assert done_o=1 while in DONE.
REQ-022 SHALL give DONE priority over halt and breakpoint.
REQ-023 SHALL wrap PC 2^ADDR_W-1 -> 0 without error.
REQ-024 SHALL resolve simultaneous events as follows:
- run_i+halt_req_i in IDLE -> stays IDLE.
- step_i in RUN/IDLE -> ignored.
- run_i and step_i in PAUSED -> RUN.
REQ-025 SHALL clear err_o only on reset or run_i from IDLE/DONE.

Reset
REQ-026 SHALL, on rst_n low at any time (including mid-instruction), immediately set state=IDLE, PC=0, ts=0, data_o=0, hold_o=1, done_o=0, err_o=0, bp_hit_o=0.
REQ-027 SHALL be in IDLE in the first cycle after rst_n deassertion and SHALL NOT start without run_i.

Configuration
REQ-028 SHALL, with BLUEBERRY_BREAKPOINT_EN defined, at a boundary in RUN with bp_en_i=1 and next PC==bp_addr_i, go PAUSED and pulse bp_hit_o for one cycle.
REQ-029 SHALL, without BLUEBERRY_BREAKPOINT_EN, keep bp_en_i/bp_addr_i present but ignored and tie bp_hit_o=0.

Structure
REQ-030 SHALL place the state enum, WORD_W/timestep width constants and the timestep encodings in shared package blueberry_pkg.
REQ-031 SHALL implement the timestep counter (clear, increment, wrap-error flag) as sub-module timestep_counter.

Verification
REQ-032 SHALL cover: program {COPY, ADD, LOAD, 0x155}, last_addr_i=3, run_i -> ts sequences 0,1 / 0,1,2,3 / 0,1; data_o=0x155 at LOAD ts=1; done_o after third boundary, PC=4.
REQ-033 SHALL cover: halt_req_i held during ADD (ts=2) -> ADD completes, PAUSED at PC=2, hold_o=1.
REQ-034 SHALL cover: step_i twice from PAUSED -> exactly one instruction each, PAUSED after each.
REQ-035 SHALL cover: undefined opcode with clr_i never asserted -> ts wraps 3->0, err_o=1 and stays set.
REQ-036 SHALL cover: rst_n low at ts=2 of an ALU op -> all outputs at reset values same cycle; IDLE after release.
REQ-037 SHALL cover: BLUEBERRY_BREAKPOINT_EN, bp_addr_i=2, bp_en_i=1 -> PAUSED at PC=2 with one-cycle bp_hit_o; macro undefined -> runs to DONE.
